ram_dp_fifo_ctrl: RTL



---
 rtl/ram_dp_fifo_pkg.sv | 23 ++
 rtl/ram_dp_fifo_obuf.sv | 60 ++++++
 rtl/ram_dp_fifo_ctrl.sv | 100 ++++++++++
 3 files changed

// File: rtl/ram_dp_fifo_pkg.sv
// ram_dp_fifo_pkg
// Shared definitions for the dual-port-RAM FIFO controller:
//   OBUF_DEPTH   - depth of the prefetch/output buffer
//   HS_DW        - data width of the generic stream handshake bundle
//   count_width  - width of an occupancy counter for a 2**aw word store
//   stream_hs_t  - valid/ready/data handshake bundle
package ram_dp_fifo_pkg;

  localparam int OBUF_DEPTH = 2;
  localparam int HS_DW      = 16;

  // Occupancy runs 0..2**aw inclusive, so it needs one bit more than the address.
  function automatic int count_width(input int aw);
    return aw + 1;
  endfunction

  typedef struct packed {
    logic             valid;
    logic             ready;
    logic [HS_DW-1:0] data;
  } stream_hs_t;

endpackage

// File: rtl/ram_dp_fifo_obuf.sv
// ram_dp_fifo_obuf
// Two-entry output buffer that captures RAM read data and presents it as a
// first-word-fall-through stream.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset (empties the buffer)
//   wr_en     - capture wr_data this cycle
//   wr_data   - word returned by the RAM read port
//   pop       - head word consumed this cycle (only asserted while valid)
//   buf_cnt   - number of words held, 0..2
//   valid     - buffer not empty
//   data      - head word
module ram_dp_fifo_obuf
  import ram_dp_fifo_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          pop,
  output logic [1:0]    buf_cnt,
  output logic          valid,
  output logic [DW-1:0] data
);

  logic [DW-1:0] mem [OBUF_DEPTH];
  logic          wr_ptr_reg;
  logic          rd_ptr_reg;
  logic [1:0]    cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      cnt_reg    <= 2'd0;
    end else begin
      if (wr_en) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)   rd_ptr_reg <= ~rd_ptr_reg;
      // Capture and pop may coincide; the count then stays put.
      cnt_reg <= cnt_reg + 2'(wr_en) - 2'(pop);
    end
  end

  // Storage carries no reset: stale words are never visible because the
  // count and pointers are cleared.
  genvar gi;
  generate
    for (gi = 0; gi < OBUF_DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (wr_en && (wr_ptr_reg == 1'(gi))) mem[gi] <= wr_data;
      end
    end
  endgenerate

  assign buf_cnt = cnt_reg;
  assign valid   = (cnt_reg != 2'd0);
  assign data    = mem[rd_ptr_reg];

endmodule

// File: rtl/ram_dp_fifo_ctrl.sv
// ram_dp_fifo_ctrl
// Single-clock FIFO controller driving the system side of a dual-port RAM.
// Port A writes incoming words; port B prefetches into a 2-entry output
// buffer that feeds a first-word-fall-through output stream.
// Ports:
//   clk, rst            - clock (also the RAM clocks), async active-high reset
//   in_valid/in_ready/in_data    - upstream stream
//   out_valid/out_ready/out_data - downstream stream
//   count               - words held in RAM + in flight + output buffer
//   w_a, a_a, d_a       - RAM port A write strobe/address/data
//   w_b, a_b, d_b       - RAM port B strobe (0)/address/data (0)
//   q_b                 - RAM port B read data, one cycle after a_b
module ram_dp_fifo_ctrl
  import ram_dp_fifo_pkg::*;
#(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW:0]   count,
  output logic          w_a,
  output logic [AW-1:0] a_a,
  output logic [DW-1:0] d_a,
  output logic          w_b,
  output logic [AW-1:0] a_b,
  output logic [DW-1:0] d_b,
  input  logic [DW-1:0] q_b
);

  localparam int              CW       = count_width(AW);
  localparam logic [CW-1:0]   FIFO_CAP = {1'b1, {AW{1'b0}}};

  logic [AW-1:0] wptr_reg;
  logic [AW-1:0] fptr_reg;
  logic [CW-1:0] mem_cnt_reg;
  logic          inflight_reg;

  logic [1:0]    buf_cnt;
  logic          push;
  logic          pop;
  logic          fetch;
  logic [1:0]    occ;

  // Occupancy comes from registered state only, so a pop in the same cycle
  // never re-opens the input.
  assign count    = mem_cnt_reg + CW'(inflight_reg) + CW'(buf_cnt);
  assign in_ready = (count < FIFO_CAP);
  assign push     = in_valid & in_ready;
  assign pop      = out_valid & out_ready;

  // Words already committed to the buffer (held or arriving next cycle).
  // A new fetch is allowed while that stays within the buffer depth,
  // counting a same-cycle pop as freeing a slot.
  assign occ   = buf_cnt + {1'b0, inflight_reg};
  assign fetch = (mem_cnt_reg != '0) &&
                 ((occ < 2'(OBUF_DEPTH)) || ((occ == 2'(OBUF_DEPTH)) && pop));

  assign w_a = push;
  assign a_a = wptr_reg;
  assign d_a = in_data;
  assign w_b = 1'b0;
  assign a_b = fptr_reg;
  assign d_b = '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_reg     <= '0;
      fptr_reg     <= '0;
      mem_cnt_reg  <= '0;
      inflight_reg <= 1'b0;
    end else begin
      if (push)  wptr_reg <= wptr_reg + 1'b1;
      if (fetch) fptr_reg <= fptr_reg + 1'b1;
      mem_cnt_reg  <= mem_cnt_reg + CW'(push) - CW'(fetch);
      // q_b is valid the cycle after the fetch; this flag marks it for capture.
      inflight_reg <= fetch;
    end
  end

  ram_dp_fifo_obuf #(
    .DW (DW)
  ) u_obuf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (inflight_reg),
    .wr_data (q_b),
    .pop     (pop),
    .buf_cnt (buf_cnt),
    .valid   (out_valid),
    .data    (out_data)
  );

endmodule
